// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM port-1 arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 128;
  localparam int RD_LAT_DEF     = 1;
  localparam int STARVE_MAX_DEF = 1024;

  // Arbiter sequencing states for one buffered scan request
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PEND  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  // Kind of the buffered scan request
  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } req_type_t;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Saturating starvation counter: counts ungranted waiting cycles of a
// pending scan request and flags when the forced-steal threshold is reached.
module sram_arb_starve_cnt #(
  parameter int STARVE_MAX = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int               CNT_W   = $clog2(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Clear outside the wait, count ungranted cycles, hold at the threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = (cnt_r == CNT_MAX);

endmodule

// File: rtl/sram_port1_arbiter.sv
// SRAM port-1 arbiter: core traffic passes straight through; one buffered
// scan read/write is slotted into a core idle cycle, or forced in (stalling
// the core for one cycle) once the scan request has starved long enough.
module sram_port1_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_ren,
  input  logic              scan_wen,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0] scan_wdata,
  input  logic [DATA_W-1:0] scan_bweb,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_ready,
  output logic              scan_busy,
  input  logic              core_active,
  input  logic              core_ren,
  input  logic              core_wen,
  input  logic [ADDR_W-1:0] core_raddr,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              sram_ren,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_raddr,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_bweb,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              starve_err
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  arb_state_t        state_r;
  arb_state_t        state_s;
  req_type_t         type_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] bweb_r;
  logic [2:0]        lat_cnt_r;
  logic [DATA_W-1:0] scan_rdata_r;
  logic              forced_r;
  logic              starve_err_r;
  logic              grant_s;
  logic              force_s;
  logic              hit_s;
  logic              starve_inc_s;
  logic              starve_clr_s;

  // Next-state decode and grant arbitration; an idle core or a core gap
  // wins over the forced steal so the core is only stalled when it must be
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    force_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (scan_ren || scan_wen) begin
          state_s = PEND;
        end else begin
          state_s = IDLE;
        end
      end
      PEND: begin
        if (!core_active || (!core_ren && !core_wen)) begin
          grant_s = 1'b1;
          state_s = ISSUE;
        end else if (hit_s) begin
          grant_s = 1'b1;
          force_s = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = PEND;
        end
      end
      ISSUE: begin
        if (type_r == WR) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_r == LAT_LAST) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus the one-cycle stall flag and sticky starvation flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      forced_r     <= 1'b0;
      starve_err_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      forced_r     <= force_s;
      starve_err_r <= starve_err_r | force_s;
    end
  end

  // Buffer the scan request when accepted; a simultaneous write beats the read
  always_ff @(posedge clk) begin
    if (rst) begin
      type_r  <= RD;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      bweb_r  <= {DATA_W{1'b0}};
    end else if ((state_r == IDLE) && (scan_ren || scan_wen)) begin
      type_r  <= scan_wen ? WR : RD;
      addr_r  <= scan_addr;
      wdata_r <= scan_wdata;
      bweb_r  <= scan_bweb;
    end else begin
      type_r  <= type_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      bweb_r  <= bweb_r;
    end
  end

  // Read-latency counter and capture of returning read data
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_r    <= 3'd0;
      scan_rdata_r <= {DATA_W{1'b0}};
    end else if (state_r == WAIT) begin
      lat_cnt_r    <= lat_cnt_r + 3'd1;
      scan_rdata_r <= (lat_cnt_r == LAT_LAST) ? sram_rdata : scan_rdata_r;
    end else begin
      lat_cnt_r    <= 3'd0;
      scan_rdata_r <= scan_rdata_r;
    end
  end

  // Port-1 mux: buffered scan access in ISSUE, core pass-through otherwise
  always_comb begin
    sram_ren   = core_ren;
    sram_wen   = core_wen;
    sram_raddr = core_raddr;
    sram_waddr = core_waddr;
    sram_wdata = core_wdata;
    sram_bweb  = {DATA_W{1'b0}};
    if (state_r == ISSUE) begin
      sram_raddr = addr_r;
      sram_waddr = addr_r;
      sram_wdata = wdata_r;
      if (type_r == WR) begin
        sram_ren  = 1'b0;
        sram_wen  = 1'b1;
        sram_bweb = bweb_r;
      end else begin
        sram_ren  = 1'b1;
        sram_wen  = 1'b0;
        sram_bweb = {DATA_W{1'b0}};
      end
    end else begin
      sram_ren   = core_ren;
      sram_wen   = core_wen;
      sram_raddr = core_raddr;
      sram_waddr = core_waddr;
      sram_wdata = core_wdata;
      sram_bweb  = {DATA_W{1'b0}};
    end
  end

  assign starve_inc_s = (state_r == PEND) && !grant_s;
  assign starve_clr_s = (state_r != PEND);

  sram_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk(clk),
    .rst(rst),
    .clr(starve_clr_s),
    .inc(starve_inc_s),
    .hit(hit_s)
  );

  assign scan_rdata = scan_rdata_r;
  assign scan_ready = (state_r == RESP);
  assign scan_busy  = (state_r == PEND) || (state_r == ISSUE) || (state_r == WAIT);
  assign core_stall = forced_r;
  assign starve_err = starve_err_r;

endmodule

// File: tb/tb_sram_port1_arbiter.sv
// Self-checking bench for sram_port1_arbiter (RD_LAT=2, STARVE_MAX=8).
module tb_sram_port1_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 128;
  localparam int LAT  = 2;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_ren, scan_wen;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_wdata, scan_bweb, scan_rdata;
  logic          scan_ready, scan_busy;
  logic          core_active, core_ren, core_wen;
  logic [AW-1:0] core_raddr, core_waddr;
  logic [DW-1:0] core_wdata;
  logic          core_stall;
  logic          sram_ren, sram_wen;
  logic [AW-1:0] sram_raddr, sram_waddr;
  logic [DW-1:0] sram_wdata, sram_bweb, sram_rdata;
  logic          starve_err;

  always #5 clk = ~clk;

  sram_port1_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .scan_ren(scan_ren), .scan_wen(scan_wen), .scan_addr(scan_addr),
    .scan_wdata(scan_wdata), .scan_bweb(scan_bweb), .scan_rdata(scan_rdata),
    .scan_ready(scan_ready), .scan_busy(scan_busy),
    .core_active(core_active), .core_ren(core_ren), .core_wen(core_wen),
    .core_raddr(core_raddr), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .core_stall(core_stall),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_raddr(sram_raddr),
    .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .sram_bweb(sram_bweb),
    .sram_rdata(sram_rdata), .starve_err(starve_err)
  );

  // Behavioural SRAM: bweb bit 1 keeps the old bit, read data after LAT edges
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe0, pipe1;
  always @(posedge clk) begin
    if (sram_wen) mem[sram_waddr] <= (mem[sram_waddr] & sram_bweb) | (sram_wdata & ~sram_bweb);
    if (sram_ren) pipe0 <= mem[sram_raddr];
    pipe1 <= pipe0;
  end
  assign sram_rdata = pipe1;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  typedef struct {
    bit            is_rd;
    logic [DW-1:0] rdata;
    int            due;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] bw;
    int            lat;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vec [8];

  int            ready_cnt, wen_cnt, ren_cnt, stall_cnt, stall_cyc, rd12_cyc;
  logic [AW-1:0] last_waddr, last_raddr;
  logic [DW-1:0] last_wdata, last_bweb;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    ready_cnt = 0; wen_cnt = 0; ren_cnt = 0; stall_cnt = 0;
    stall_cyc = -1; rd12_cyc = -1;
  endtask

  task automatic push_exp(input bit is_rd, input logic [DW-1:0] rd, input int due);
    sb_t e;
    e.is_rd = is_rd; e.rdata = rd; e.due = due;
    sb.push_back(e);
  endtask

  task automatic scan_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] bw);
    scan_ren = rd; scan_wen = wr; scan_addr = a; scan_wdata = wd; scan_bweb = bw;
    nxt();
    scan_ren = 1'b0; scan_wen = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || scan_busy || scan_ready) && n < budget) begin
      nxt();
      n++;
    end
    chk("done_in_budget", (n < budget), 1'b1);
  endtask

  // Cycle counter: number of rising edges seen so far
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Monitor: port activity counters and scoreboard pop on scan_ready
  initial begin : mon
    sb_t e;
    forever begin
      @(negedge clk);
      if (sram_wen) begin
        wen_cnt++; last_waddr = sram_waddr; last_wdata = sram_wdata; last_bweb = sram_bweb;
      end
      if (sram_ren) begin
        ren_cnt++; last_raddr = sram_raddr;
        if (sram_raddr == 8'h12) rd12_cyc = cyc_n;
      end
      if (core_stall) begin
        stall_cnt++; stall_cyc = cyc_n;
      end
      if (scan_ready) begin
        ready_cnt++;
        if (sb.size() == 0) begin
          chk("ready_unexpected", scan_ready, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("ready_cycle", cyc_n, e.due);
          if (e.is_rd) chk("scan_rdata", scan_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int gap;
    vec[0] = '{1'b0, 1'b1, 8'h12, {16{8'hA5}}, {DW{1'b0}}, 3, {DW{1'b0}}};
    vec[1] = '{1'b1, 1'b0, 8'h12, {DW{1'b0}}, {DW{1'b0}}, 5, {16{8'hA5}}};
    vec[2] = '{1'b0, 1'b1, 8'h34, {8{16'h1111}}, {DW{1'b0}}, 3, {DW{1'b0}}};
    vec[3] = '{1'b0, 1'b1, 8'h34, {16{8'hFF}}, {{64{1'b0}}, {64{1'b1}}}, 3, {DW{1'b0}}};
    vec[4] = '{1'b1, 1'b0, 8'h34, {DW{1'b0}}, {DW{1'b0}}, 5, {{8{8'hFF}}, {4{16'h1111}}}};
    vec[5] = '{1'b1, 1'b1, 8'h56, 128'h0123456789ABCDEF_FEDCBA9876543210, {DW{1'b0}}, 3, {DW{1'b0}}};
    vec[6] = '{1'b1, 1'b0, 8'h56, {DW{1'b0}}, {DW{1'b0}}, 5, 128'h0123456789ABCDEF_FEDCBA9876543210};
    vec[7] = '{1'b1, 1'b0, 8'h12, {DW{1'b0}}, {DW{1'b0}}, 5, {16{8'hA5}}};

    rst = 1'b1;
    scan_ren = 1'b0; scan_wen = 1'b0; scan_addr = 8'h00;
    scan_wdata = {DW{1'b0}}; scan_bweb = {DW{1'b0}};
    core_active = 1'b0; core_ren = 1'b0; core_wen = 1'b0;
    core_raddr = 8'h00; core_waddr = 8'h00; core_wdata = {DW{1'b0}};
    clr_cnt();
    nxt(); nxt();
    @(negedge clk);
    chk("rst_ready", scan_ready, 1'b0);
    chk("rst_busy", scan_busy, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_starve", starve_err, 1'b0);
    chk("rst_rdata", scan_rdata, {DW{1'b0}});
    nxt();
    rst = 1'b0;

    // Core pass-through while idle; scan mask must not leak onto the port
    core_active = 1'b1; core_ren = 1'b1; core_raddr = 8'h40;
    core_wen = 1'b1; core_waddr = 8'h41; core_wdata = {4{32'hDEADBEEF}};
    scan_bweb = {DW{1'b1}};
    @(negedge clk);
    chk("pt_ren", sram_ren, 1'b1);
    chk("pt_raddr", sram_raddr, 8'h40);
    chk("pt_wen", sram_wen, 1'b1);
    chk("pt_waddr", sram_waddr, 8'h41);
    chk("pt_wdata", sram_wdata, {4{32'hDEADBEEF}});
    chk("pt_bweb", sram_bweb, {DW{1'b0}});
    nxt();
    core_active = 1'b0; core_ren = 1'b0; core_wen = 1'b0; scan_bweb = {DW{1'b0}};
    @(negedge clk);
    chk("pt_ren_off", sram_ren, 1'b0);
    chk("pt_wen_off", sram_wen, 1'b0);
    nxt();

    // Table: scan requests against an idle core
    for (int i = 0; i < 8; i++) begin
      clr_cnt();
      push_exp(!vec[i].wr, vec[i].exp_rd, cyc_n + vec[i].lat);
      scan_req(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wd, vec[i].bw);
      wait_done(30);
      chk("vec_ready_cnt", ready_cnt, 1);
      if (vec[i].wr) begin
        chk("vec_wen_cnt", wen_cnt, 1);
        chk("vec_ren_cnt", ren_cnt, 0);
        chk("vec_waddr", last_waddr, vec[i].addr);
        chk("vec_wdata", last_wdata, vec[i].wd);
        chk("vec_bweb", last_bweb, vec[i].bw);
      end else begin
        chk("vec_ren_cnt", ren_cnt, 1);
        chk("vec_wen_cnt", wen_cnt, 0);
        chk("vec_raddr", last_raddr, vec[i].addr);
      end
      chk("vec_starve", starve_err, 1'b0);
    end

    // Gap steal: busy core with one idle cycle; issue lands right after it
    clr_cnt();
    core_active = 1'b1; core_ren = 1'b1; core_raddr = 8'h40;
    nxt();
    p = cyc_n;
    push_exp(1'b1, {16{8'hA5}}, p + 9);
    scan_req(1'b1, 1'b0, 8'h12, {DW{1'b0}}, {DW{1'b0}});
    repeat (4) nxt();
    core_ren = 1'b0;
    gap = cyc_n;
    nxt();
    core_ren = 1'b1;
    wait_done(30);
    chk("gap_issue_cyc", rd12_cyc, gap + 1);
    chk("gap_stall_cnt", stall_cnt, 0);
    chk("gap_starve", starve_err, 1'b0);

    // Starvation: core never idle, forced steal after 7 ungranted cycles
    clr_cnt();
    nxt();
    p = cyc_n;
    push_exp(1'b0, {DW{1'b0}}, p + 10);
    scan_req(1'b0, 1'b1, 8'h77, {16{8'hC3}}, {DW{1'b0}});
    wait_done(30);
    chk("stv_stall_cnt", stall_cnt, 1);
    chk("stv_stall_cyc", stall_cyc, p + 9);
    chk("stv_starve", starve_err, 1'b1);
    chk("stv_wen_cnt", wen_cnt, 1);
    chk("stv_waddr", last_waddr, 8'h77);
    core_active = 1'b0; core_ren = 1'b0;
    nxt();

    // Second request while busy is ignored; starve_err stays set
    clr_cnt();
    push_exp(1'b0, {DW{1'b0}}, cyc_n + 3);
    scan_req(1'b0, 1'b1, 8'h20, {8{16'h5A5A}}, {DW{1'b0}});
    chk("busy_second", scan_busy, 1'b1);
    scan_req(1'b1, 1'b0, 8'h21, {DW{1'b0}}, {DW{1'b0}});
    wait_done(30);
    repeat (3) nxt();
    chk("busy_ready_cnt", ready_cnt, 1);
    chk("busy_ren_cnt", ren_cnt, 0);
    chk("busy_wen_cnt", wen_cnt, 1);
    chk("busy_waddr", last_waddr, 8'h20);
    chk("sticky_starve", starve_err, 1'b1);

    // Reset during WAIT: back to reset values, no completion pulse
    clr_cnt();
    scan_req(1'b1, 1'b0, 8'h12, {DW{1'b0}}, {DW{1'b0}});
    nxt();
    nxt();
    chk("wait_busy", scan_busy, 1'b1);
    rst = 1'b1;
    nxt();
    chk("mrst_busy", scan_busy, 1'b0);
    chk("mrst_ready", scan_ready, 1'b0);
    chk("mrst_stall", core_stall, 1'b0);
    chk("mrst_starve", starve_err, 1'b0);
    chk("mrst_rdata", scan_rdata, {DW{1'b0}});
    chk("mrst_sram_ren", sram_ren, 1'b0);
    rst = 1'b0;
    repeat (4) nxt();
    chk("mrst_no_ready", ready_cnt, 0);
    push_exp(1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, cyc_n + 5);
    scan_req(1'b1, 1'b0, 8'h56, {DW{1'b0}}, {DW{1'b0}});
    wait_done(30);
    chk("mrst_after_ready", ready_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
